// File: rtl/dcache_pkg.sv
// Shared types, geometry and byte-lane helpers for the 2-way write-through data cache.
package dcache_pkg;

  localparam int ADDRESS_WIDTH = 32;
  localparam int DATA_WIDTH    = 32;
  localparam int SET_WIDTH     = 8;
  localparam int INDEX_W       = SET_WIDTH;
  localparam int TAG_W         = ADDRESS_WIDTH - SET_WIDTH - 2;
  localparam int SETS          = 1 << SET_WIDTH;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_e;

  typedef struct packed {
    logic                  valid;
    logic [TAG_W-1:0]      tag;
    logic [DATA_WIDTH-1:0] data;
  } line_t;

  // Big-endian lanes: byte offset 0 lives in bits [31:24], so the lane base is {~off, 3'b000}.
  function automatic logic [7:0] byte_of(input logic [DATA_WIDTH-1:0] word, input logic [1:0] off);
    return word[{~off, 3'b000} +: 8];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_byte(input logic [DATA_WIDTH-1:0] word,
                                                       input logic [1:0] off,
                                                       input logic [7:0] value);
    logic [DATA_WIDTH-1:0] merged;
    merged = word;
    merged[{~off, 3'b000} +: 8] = value;
    return merged;
  endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side buses of the data cache.
interface dcache_cpu_if;
  logic                                 req;
  logic                                 we;
  logic                                 byte_op;
  logic [dcache_pkg::ADDRESS_WIDTH-1:0] addr;
  logic [dcache_pkg::DATA_WIDTH-1:0]    wdata;
  logic [dcache_pkg::DATA_WIDTH-1:0]    rdata;
  logic                                 stall;

  modport master (output req, we, byte_op, addr, wdata, input rdata, stall);
  modport slave  (input req, we, byte_op, addr, wdata, output rdata, stall);
endinterface

interface dcache_mem_if;
  logic                                 we;
  logic                                 byte_op;
  logic [dcache_pkg::ADDRESS_WIDTH-1:0] addr;
  logic [dcache_pkg::DATA_WIDTH-1:0]    wdata;
  logic [dcache_pkg::DATA_WIDTH-1:0]    rdata;

  modport master (output we, byte_op, addr, wdata, input rdata);
  modport slave  (input we, byte_op, addr, wdata, output rdata);
endinterface

// File: rtl/dcache_way.sv
// One cache way: valid/tag/data storage, tag compare and a byte-merging write port.
module dcache_way
  import dcache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_W-1:0]    lookup_index,
  input  logic [TAG_W-1:0]      lookup_tag,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  wr_en,
  input  logic                  wr_fill,
  input  logic                  wr_byte_op,
  input  logic [1:0]            wr_byte_sel,
  input  logic [INDEX_W-1:0]    wr_index,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [SETS-1:0]       valid_q;
  logic [TAG_W-1:0]      tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS];
  line_t                 rd_line;

  always_comb begin
    rd_line.valid = valid_q[lookup_index];
    rd_line.tag   = tag_q[lookup_index];
    rd_line.data  = data_q[lookup_index];
  end

  assign hit   = rd_line.valid && (rd_line.tag == lookup_tag);
  assign rdata = rd_line.data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en && wr_fill) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone make their contents meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_byte_op) begin
        data_q[wr_index] <= merge_byte(data_q[wr_index], wr_byte_sel, wr_data[7:0]);
      end else begin
        data_q[wr_index] <= wr_data;
      end
      if (wr_fill) begin
        tag_q[wr_index] <= wr_tag;
      end
    end
  end

endmodule

// File: rtl/data_cache.sv
// 2-way set-associative write-through / no-write-allocate data cache with one-word lines.
module data_cache
  import dcache_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input logic          clk,
  input logic          rst_n,
  dcache_cpu_if.slave  cpu,
  dcache_mem_if.master mem
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [SETS-1:0]          lru_q;
  logic [ADDRESS_WIDTH-1:0] maddr_q;
  logic [DATA_WIDTH-1:0]    mwdata_q;
  logic                     mbop_q;

  logic [INDEX_W-1:0]    cpu_index, fill_index, wr_index, lru_index;
  logic [TAG_W-1:0]      cpu_tag, fill_tag;
  logic [1:0]            hit_way, way_wr_en;
  logic [DATA_WIDTH-1:0] way_rdata [2];
  logic [DATA_WIDTH-1:0] hit_word, wr_data;
  logic                  hit_sel, victim;
  logic                  wr_fill, wr_byte_op, lru_we, lru_val;
  logic [1:0]            wr_byte_sel;
  logic                  latch_refill, latch_write;

  assign cpu_index  = cpu.addr[SET_WIDTH+1:2];
  assign cpu_tag    = cpu.addr[ADDRESS_WIDTH-1:SET_WIDTH+2];
  assign fill_index = maddr_q[SET_WIDTH+1:2];
  assign fill_tag   = maddr_q[ADDRESS_WIDTH-1:SET_WIDTH+2];
  assign hit_sel    = hit_way[1];
  assign hit_word   = way_rdata[hit_sel];
  assign victim     = lru_q[fill_index];

  for (genvar w = 0; w < 2; w++) begin : g_way
    dcache_way u_way (
      .clk          (clk),
      .rst_n        (rst_n),
      .lookup_index (cpu_index),
      .lookup_tag   (cpu_tag),
      .hit          (hit_way[w]),
      .rdata        (way_rdata[w]),
      .wr_en        (way_wr_en[w]),
      .wr_fill      (wr_fill),
      .wr_byte_op   (wr_byte_op),
      .wr_byte_sel  (wr_byte_sel),
      .wr_index     (wr_index),
      .wr_tag       (fill_tag),
      .wr_data      (wr_data)
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Requests are ignored while rst_n is low so stall and the array write ports drop with reset.
  always_comb begin
    state_d      = state_q;
    cpu.stall    = 1'b0;
    cpu.rdata    = '0;
    mem.we       = 1'b0;
    way_wr_en    = '0;
    wr_fill      = 1'b0;
    wr_byte_op   = 1'b0;
    wr_byte_sel  = cpu.addr[1:0];
    wr_index     = cpu_index;
    wr_data      = cpu.wdata;
    lru_we       = 1'b0;
    lru_index    = cpu_index;
    lru_val      = 1'b0;
    latch_refill = 1'b0;
    latch_write  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu.req && rst_n) begin
          if (cpu.we) begin
            cpu.stall   = 1'b1;
            latch_write = 1'b1;
            way_wr_en   = hit_way;
            wr_byte_op  = cpu.byte_op;
            lru_we      = |hit_way;
            lru_val     = ~hit_sel;
            state_d     = WRITE;
          end else if (|hit_way) begin
            cpu.rdata = cpu.byte_op ? {{(DATA_WIDTH-8){1'b0}}, byte_of(hit_word, cpu.addr[1:0])}
                                    : hit_word;
            lru_we    = 1'b1;
            lru_val   = ~hit_sel;
          end else begin
            cpu.stall    = 1'b1;
            latch_refill = 1'b1;
            state_d      = REFILL;
          end
        end
      end
      REFILL: begin
        cpu.stall = 1'b1;
        if (cnt_q == CNT_W'(MEM_LATENCY - 1)) begin
          way_wr_en[victim] = 1'b1;
          wr_fill           = 1'b1;
          wr_index          = fill_index;
          wr_data           = mem.rdata;
          lru_we            = 1'b1;
          lru_index         = fill_index;
          lru_val           = ~victim;
          state_d           = IDLE;
        end
      end
      WRITE: begin
        mem.we  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == REFILL) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lru_q <= '0;
    end else if (lru_we) begin
      lru_q[lru_index] <= lru_val;
    end
  end

  // The memory-side registers double as the latched request, so mem_* hold between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maddr_q  <= '0;
      mwdata_q <= '0;
      mbop_q   <= 1'b0;
    end else if (latch_refill) begin
      maddr_q <= {cpu.addr[ADDRESS_WIDTH-1:2], 2'b00};
      mbop_q  <= 1'b0;
    end else if (latch_write) begin
      maddr_q  <= cpu.addr;
      mwdata_q <= cpu.wdata;
      mbop_q   <= cpu.byte_op;
    end
  end

  assign mem.addr    = maddr_q;
  assign mem.wdata   = mwdata_q;
  assign mem.byte_op = mbop_q;

endmodule
